// File: rtl/aca_csu16_recover.sv
// aca_csu16_recover
//   Variable-latency error-recovery wrapper around a 16-bit ACA-CSU
//   approximate adder built from 2-bit blocks. An operand pair is accepted
//   in IDLE. One SPEC cycle registers the speculative sum. If every
//   speculative block carry matches the true ripple carry, the sum goes out
//   directly. Otherwise the wrong blocks are repaired, so every result
//   equals a+b exactly.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   a, b       [15:0]   operands, sampled on in_valid & in_ready
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   sum        [16:0]   exact a+b, held stable while out_valid
//   out_valid/out_ready output handshake
//   err                 result needed correction (valid with out_valid)
//   err_cnt    [15:0]   saturating count of corrected results
//
// Handshakes: a transfer occurs on a rising edge where valid and ready are
// both high. Once valid is raised, the producer holds valid and data until
// that edge.
//
// Build option: define ACA_FIX_1CYC_EN to repair in a single FIX cycle by
// loading the full-width sum. Without it, FIX ripples one block per cycle
// from the first wrong block up to block 7.
module aca_csu16_recover (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [16:0] sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SPEC, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] a_q, b_q;
    logic [2:0]  idx;
    logic        carry_reg;

    // Speculation and error detection on the latched operands
    logic [15:0] p, g, ripple_c;
    logic [16:0] exact, spec_sum;
    logic [7:0]  c_spec, c_ex;
    logic [2:0]  blk_spec;
    logic [2:0]  f;
    logic        has_err;

    always_comb begin
        p        = a_q ^ b_q;
        g        = a_q & b_q;
        exact    = {1'b0, a_q} + {1'b0, b_q};
        // The true carry into each bit is recovered from the exact sum.
        ripple_c = exact[15:0] ^ p;
        c_spec   = '0;
        c_ex     = '0;
        spec_sum = '0;
        blk_spec = '0;
        f        = '0;
        has_err  = 1'b0;

        c_spec[1] = g[1] | (p[1] & g[0]);
        for (int k = 2; k < 8; k++) begin
            if (p[2*k-1] & p[2*k-2])
                c_spec[k] = g[2*k-3];
            else
                c_spec[k] = g[2*k-1] | (p[2*k-1] & g[2*k-2]);
        end

        for (int k = 0; k < 8; k++) begin
            c_ex[k]           = ripple_c[2*k];
            blk_spec          = {1'b0, a_q[2*k +: 2]} + {1'b0, b_q[2*k +: 2]}
                                + {2'b00, c_spec[k]};
            spec_sum[2*k +: 2] = blk_spec[1:0];
        end
        // The loop ends on block 7, whose carry-out becomes sum[16].
        spec_sum[16] = blk_spec[2];

        // Scanning downward leaves f at the lowest mismatching block.
        for (int k = 7; k >= 2; k--) begin
            if (c_spec[k] != c_ex[k]) begin
                has_err = 1'b1;
                f       = 3'(k);
            end
        end
    end

    // Block repair adder for the block-serial FIX
    logic [3:0] fix_pos;
    logic [2:0] fix_blk;

    always_comb begin
        fix_pos = {idx, 1'b0};
        fix_blk = {1'b0, a_q[fix_pos +: 2]} + {1'b0, b_q[fix_pos +: 2]}
                  + {2'b00, carry_reg};
    end

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SPEC;
            end
            SPEC: state_nxt = has_err ? FIX : DONE;
            FIX: begin
`ifdef ACA_FIX_1CYC_EN
                state_nxt = DONE;
`else
                if (idx == 3'd7) state_nxt = DONE;
`endif
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                SPEC: begin
                    sum <= spec_sum;
                    err <= has_err;
                    if (has_err) begin
                        idx       <= f;
                        carry_reg <= c_ex[f];
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                FIX: begin
`ifdef ACA_FIX_1CYC_EN
                    sum       <= exact;
                    out_valid <= 1'b1;
`else
                    sum[fix_pos +: 2] <= fix_blk[1:0];
                    carry_reg         <= fix_blk[2];
                    if (idx == 3'd7) begin
                        sum[16]   <= fix_blk[2];
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (err && (err_cnt != 16'hFFFF))
                            err_cnt <= err_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aca_csu16_recover.md
# aca_csu16_recover

Variable-latency error-recovery wrapper for the 16-bit ACA-CSU approximate adder with 2-bit blocks. It accepts an operand pair through a valid/ready handshake and computes the speculative sum in one cycle. When the speculation is exact, it returns that sum immediately. Otherwise it repairs the sum block by block, so every returned sum equals a+b exactly. It sits downstream of operand sources that need exact results while still gaining the fast path of the approximate adder.

## Interface
- No parameters.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- a  in  16  operand A, sampled on input handshake.
- b  in  16  operand B, sampled on input handshake.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in IDLE.
- sum  out  17  exact a+b, valid while out_valid.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- err  out  1  result required correction; valid with out_valid.
- err_cnt  out  16  saturating count of corrected operations.

## Operation
- Blocks Bk = bits [2k+1:2k], k=0..7. p=a^b, g=a&b, P(Bk)=p[2k+1]&p[2k].
- Speculative carry into each block:
  - c_spec[0]=0.
  - c_spec[1]=g1|p1&g0, which is exact.
  - k≥2: c_spec[k] = g[2k-3] if P(Bk-1); otherwise g[2k-1]|p[2k-1]&g[2k-2].
- c_ex[k] is the true ripple carry. The speculative sum uses c_spec per block; sum[16] is the cout of B7 with c_spec[7].
- f is the lowest k (2..7) with c_spec[k]≠c_ex[k]. If no such k exists, there is no error.
- States:
  - IDLE: in_ready=1. in_valid=1 latches a,b → SPEC.
  - SPEC (1 cycle): register the speculative sum. No error → DONE with err=0. Error → FIX with idx=f, carry_reg=c_ex[f], err=1.
  - FIX: each cycle rewrites block idx from carry_reg, and carry_reg takes that block's cout. At idx=7, sum[16] is set to the B7 cout, then → DONE. Otherwise idx++.
  - DONE: out_valid=1. out_ready=1 → IDLE. err_cnt increments on the leaving edge if err=1, saturating at 0xFFFF.
- Exactly one operation is in flight. sum, err and out_valid are registered and stay stable in DONE until out_ready.

## Timing
- Reset values: sum=0, out_valid=0, err=0, err_cnt=0, state IDLE (in_ready=1), idx=0, carry_reg=0.
- Cycle 0 is the edge where in_valid&in_ready. SPEC occupies cycle 1.
- No error: out_valid rises at cycle 2.
- Error, ripple build: 8-f FIX cycles, so out_valid rises at cycle 2+(8-f). Range is 3..8.
- Output handshake completes on the edge with out_valid&out_ready. in_ready is 1 the following cycle; there is no same-cycle re-accept.
- in_valid outside IDLE is ignored. Operands are not held by the source after acceptance.
- rst at any time, including mid-FIX or in DONE, returns to reset values immediately. The in-flight operation is discarded and err_cnt clears.

## Configuration
- ACA_FIX_1CYC_EN defined: FIX lasts exactly one cycle. sum is loaded with the exact a+b, and error latency is fixed at 3 cycles (out_valid at cycle 3).
- Not defined: the block-serial ripple FIX above, with latency 2+(8-f).
- The no-error path, handshakes, err and err_cnt are identical in both builds.

## Test plan
- a=0x1234, b=0x4321 → out_valid at cycle 2, sum=0x05555, err=0, err_cnt=0.
- a=0x000F, b=0x0001: speculative sum 0x00000, f=2 → sum=0x00010, err=1. out_valid at cycle 8, or cycle 3 with ACA_FIX_1CYC_EN. err_cnt=1 after the handshake.
- a=0xFFFF, b=0x0001: speculative sum 0x0FFF0, f=2 → sum=0x10000, err=1. Same latencies as the previous case.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum, err and out_valid stay stable, in_ready=0, and a pulsed in_valid is ignored. On release, in_ready=1 on the next cycle.
- Reset during FIX (second FIX cycle of the 0x000F case) → all outputs at reset values immediately and in_ready=1. A new a=0x0001, b=0x0001 then returns sum=0x00002, err=0 at cycle 2.
- Back-to-back: three erroring operations, each accepted in the cycle in_ready returns → err_cnt=3.
